// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate back end.
package mac_pkg;

    localparam int PRODUCT_W = 16;
    localparam int ACC_W_DEF = 24;
    localparam int COUNT_DEF = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Product-in / result-out handshake bundle of the dot-product accumulator.
interface dot_product_accumulator_if
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PRODUCT_W-1:0] in_product;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ovf;

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/acc_sat_add.sv
// Accumulator adder: acc + sign-extended product at ACC_W+1 bits.
// ACC_SATURATE_EN selects clamping with overflow flag; otherwise the sum wraps.
module acc_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic [PRODUCT_W-1:0] product,
    output logic [ACC_W-1:0]     sum,
    output logic                 ovf
);
    logic [ACC_W:0] wide;

    assign wide = {acc[ACC_W-1], acc}
                + {{(ACC_W + 1 - PRODUCT_W){product[PRODUCT_W-1]}}, product};

`ifdef ACC_SATURATE_EN
    logic ovf_raw;

    // Top two bits disagree only when the true result left the ACC_W range.
    assign ovf_raw = wide[ACC_W] ^ wide[ACC_W-1];
    assign ovf     = ovf_raw;
    assign sum     = !ovf_raw     ? wide[ACC_W-1:0] :
                     wide[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
`else
    logic unused_msb;

    assign unused_msb = wide[ACC_W];
    assign sum        = wide[ACC_W-1:0];
    assign ovf        = 1'b0;
`endif

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums blocks of up to COUNT signed products and holds each result on an output handshake.
// Build option: ACC_SATURATE_EN (saturating accumulator with sticky overflow flag).
module dot_product_accumulator
    import mac_pkg::*;
#(
    parameter  int ACC_W = ACC_W_DEF,
    parameter  int COUNT = COUNT_DEF,
    localparam int CNT_W = $clog2(COUNT + 1)
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic                       clear,
    dot_product_accumulator_if.slave  bus
);
    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             close_block;

    acc_sat_add #(.ACC_W(ACC_W)) u_add (
        .acc     (acc_reg),
        .product (bus.in_product),
        .sum     (add_sum),
        .ovf     (add_ovf)
    );

    assign close_block = bus.in_last || (cnt_reg == CNT_W'(COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        // clear outranks both handshakes, including a beat offered while in_ready is high.
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_next = add_sum;
                        cnt_next = cnt_reg + CNT_W'(1);
                        ovf_next = ovf_reg | add_ovf;
                        if (close_block) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_sum   = acc_reg;
    assign bus.out_count = cnt_reg;
    assign bus.out_ovf   = ovf_reg;

endmodule
